// File: rtl/non_restoring_division_controller.sv
// Sequencer for a 16-bit non-restoring divider datapath.
// Optional divide-by-zero short cut: define NRD_DIV_ZERO_CHECK_EN.
module non_restoring_division_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] divisor,
   input  logic        a_sign,
   output logic        select_A,
   output logic        select_Q,
   output logic        ld_A,
   output logic        ld_Q,
   output logic        shift_left_enable_a,
   output logic        shift_left_enable_q,
   output logic        count_enable,
   output logic        restore_en,
   output logic        busy,
   output logic        done,
   output logic        dz_error,
   output logic [4:0]  iter_count
);

`ifdef NRD_DIV_ZERO_CHECK_EN
   localparam bit ZERO_CHECK = 1'b1;
`else
   localparam bit ZERO_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SHIFT   = 3'd2,
      ADDSUB  = 3'd3,
      CORRECT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t state;
   state_t state_next;
   logic   div_zero;
   logic   dz_q;

   assign div_zero = (divisor == 16'd0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Count saturates at 16 and holds until the next LOAD.
   always_ff @(posedge clk) begin
      if (rst)
         iter_count <= 5'd0;
      else if (state == LOAD)
         iter_count <= 5'd0;
      else if (state == ADDSUB && iter_count != 5'd16)
         iter_count <= iter_count + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         dz_q <= 1'b0;
      else if (state == IDLE && start)
         dz_q <= ZERO_CHECK && div_zero;
   end

   assign dz_error = dz_q;

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_next = (ZERO_CHECK && div_zero) ? DONE : LOAD;
         end
         LOAD:    state_next = SHIFT;
         SHIFT:   state_next = ADDSUB;
         ADDSUB: begin
            if (iter_count < 5'd15) state_next = SHIFT;
            else                    state_next = CORRECT;
         end
         CORRECT: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      select_A            = 1'b0;
      select_Q            = 1'b0;
      ld_A                = 1'b0;
      ld_Q                = 1'b0;
      shift_left_enable_a = 1'b0;
      shift_left_enable_q = 1'b0;
      count_enable        = 1'b0;
      restore_en          = 1'b0;
      busy                = (state != IDLE);
      done                = 1'b0;
      unique case (state)
         IDLE: ;
         LOAD: begin
            ld_A = 1'b1;
            ld_Q = 1'b1;
         end
         SHIFT: begin
            shift_left_enable_a = 1'b1;
            shift_left_enable_q = 1'b1;
         end
         ADDSUB: begin
            ld_A         = 1'b1;
            select_A     = 1'b1;
            ld_Q         = 1'b1;
            select_Q     = 1'b1;
            count_enable = 1'b1;
         end
         // A negative final remainder gets the divisor added back.
         CORRECT: begin
            restore_en = a_sign;
            ld_A       = a_sign;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule
